// File: rtl/fetch_queue.sv
// fetch_queue -- instruction prefetch queue between a registered ROM and the
// IF/ID register.
//
// A single outstanding ROM request ("pending") is tracked alongside the queue
// occupancy. A new request is only issued when the queue can absorb it, so the
// queue never overflows.
//
// Ports
//   CLK             clock, all state on rising edge
//   RESET_N         asynchronous active-low reset
//   redirect        flush queue and restart fetch at redirect_pc
//   redirect_pc     byte target address, bits [1:0] ignored
//   deq_ready       consumer accepts the head entry this cycle
//   iaddr           word address to the registered ROM
//   idata           ROM data, valid one cycle after iaddr
//   out_valid       head entry present
//   out_pc          byte PC of the head entry (0 when empty)
//   out_inst        instruction of the head entry (NOP when empty)
//   redirect_count  redirects taken, saturating      (FETCH_QUEUE_PERF_EN only)
//   empty_cycles    cycles with out_valid low, saturating (FETCH_QUEUE_PERF_EN only)
//
// Build option: define FETCH_QUEUE_PERF_EN to add the performance counters.

module fetch_queue #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int DEPTH     = 4
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   redirect,
    input  logic [ADDR_SIZE+1:0]   redirect_pc,
    input  logic                   deq_ready,
    output logic [ADDR_SIZE-1:0]   iaddr,
    input  logic [DATA_SIZE-1:0]   idata,
    output logic                   out_valid,
    output logic [ADDR_SIZE+1:0]   out_pc,
    output logic [DATA_SIZE-1:0]   out_inst
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [15:0]            redirect_count,
    output logic [15:0]            empty_cycles
`endif
);

    localparam int PC_W  = ADDR_SIZE + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DATA_SIZE-1:0] NOP = DATA_SIZE'(32'h0000_0013);

    logic [PC_W-1:0]      fetch_pc;
    logic                 pending;
    logic [PC_W-1:0]      pend_pc;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    logic [PC_W-1:0]      mem_pc   [DEPTH];
    logic [DATA_SIZE-1:0] mem_inst [DEPTH];

    logic [CNT_W:0]       in_flight;
    logic                 issue;
    logic                 do_enq;
    logic                 do_deq;

    assign iaddr = fetch_pc[PC_W-1:2];

    // Credit check: queued entries plus the response still in flight must
    // leave room for one more, otherwise the response could land in a full queue.
    assign in_flight = {1'b0, count} + (CNT_W+1)'(pending);
    assign issue     = !redirect && (in_flight < (CNT_W+1)'(DEPTH));
    assign do_enq    = pending && !redirect;
    assign out_valid = (count != '0);
    assign do_deq    = out_valid && deq_ready && !redirect;

    assign out_pc    = out_valid ? mem_pc[head]   : '0;
    assign out_inst  = out_valid ? mem_inst[head] : NOP;

    // Storage is deliberately left without reset; count gates visibility.
    always_ff @(posedge CLK) begin
        if (do_enq) begin
            mem_pc[tail]   <= pend_pc;
            mem_inst[tail] <= idata;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_pc <= '0;
            pending  <= 1'b0;
            pend_pc  <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            // Redirect overrides any enqueue/dequeue and kills the pending response.
            fetch_pc <= redirect_pc & ~PC_W'(3);
            pending  <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + PC_W'(4);
                pend_pc  <= fetch_pc;
            end
            pending <= issue;
            if (do_enq) tail <= tail + PTR_W'(1);
            if (do_deq) head <= head + PTR_W'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            redirect_count <= '0;
            empty_cycles   <= '0;
        end else begin
            if (redirect && (redirect_count != 16'hFFFF))
                redirect_count <= redirect_count + 16'd1;
            if (!out_valid && (empty_cycles != 16'hFFFF))
                empty_cycles <= empty_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int AS   = 10;
    localparam int PC_W = AS + 2;
    localparam int DEP  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            CLK;
    logic            RESET_N;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            deq_ready;
    logic [AS-1:0]   iaddr;
    logic [31:0]     idata;
    logic            out_valid;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_inst;
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0]     redirect_count;
    logic [15:0]     empty_cycles;
`endif

    int checks = 0;
    int errors = 0;
    bit run    = 0;

    fetch_queue #(.DATA_SIZE(32), .ADDR_SIZE(AS), .DEPTH(DEP)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .deq_ready(deq_ready),
        .iaddr(iaddr),
        .idata(idata),
        .out_valid(out_valid),
        .out_pc(out_pc),
        .out_inst(out_inst)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .redirect_count(redirect_count),
        .empty_cycles(empty_cycles)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ROM word k holds k.
    function automatic logic [31:0] rom(input logic [AS-1:0] a);
        return {{(32-AS){1'b0}}, a};
    endfunction

    always @(posedge CLK) idata <= rom(iaddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched entries, one in-flight ROM response.
    logic [PC_W-1:0] q_pc[$];
    logic [31:0]     q_inst[$];
    logic            m_pend;
    logic [PC_W-1:0] m_ppc;
    logic [PC_W-1:0] m_fpc;
    logic [15:0]     m_rc;
    logic [15:0]     m_ec;

    always @(posedge CLK or negedge RESET_N) begin
        bit m_issue;
        bit m_valid;
        if (!RESET_N) begin
            q_pc.delete();
            q_inst.delete();
            m_pend = 1'b0;
            m_ppc  = '0;
            m_fpc  = '0;
            m_rc   = '0;
            m_ec   = '0;
        end else begin
            m_valid = (q_pc.size() != 0);
            m_issue = !redirect && ((q_pc.size() + int'(m_pend)) < DEP);
            if (!m_valid && m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
            if (redirect) begin
                q_pc.delete();
                q_inst.delete();
                m_pend = 1'b0;
                m_fpc  = {redirect_pc[PC_W-1:2], 2'b00};
                if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
            end else begin
                if (m_valid && deq_ready) begin
                    void'(q_pc.pop_front());
                    void'(q_inst.pop_front());
                end
                if (m_pend) begin
                    q_pc.push_back(m_ppc);
                    q_inst.push_back(rom(m_ppc[PC_W-1:2]));
                end
                if (m_issue) begin
                    m_ppc = m_fpc;
                    m_fpc = m_fpc + PC_W'(4);
                end
                m_pend = m_issue;
                if (q_pc.size() > DEP) begin
                    errors++;
                    $display("FAIL model_overflow size=%0d t=%0t", q_pc.size(), $time);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (run && RESET_N === 1'b1) begin
            chk("m_valid", {31'b0, out_valid}, {31'b0, q_pc.size() != 0});
            chk("m_pc",    32'(out_pc),   (q_pc.size() != 0) ? 32'(q_pc[0]) : 32'h0);
            chk("m_inst",  out_inst,      (q_pc.size() != 0) ? q_inst[0] : NOP);
            chk("m_iaddr", 32'(iaddr),    32'(m_fpc[PC_W-1:2]));
`ifdef FETCH_QUEUE_PERF_EN
            chk("m_rcnt",  32'(redirect_count), 32'(m_rc));
            chk("m_ecyc",  32'(empty_cycles),   32'(m_ec));
`endif
        end
    end

    task automatic do_redirect(input logic [PC_W-1:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(negedge CLK);
        redirect    = 1'b0;
    endtask

    initial begin
        RESET_N     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        deq_ready   = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N   = 1'b1;
        run       = 1'b1;
        deq_ready = 1'b1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc",    32'(out_pc), 32'd0);
        chk("rst_inst",  out_inst, NOP);
        chk("rst_iaddr", 32'(iaddr), 32'd0);
        @(negedge CLK);
        chk("c1_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("seq_valid", {31'b0, out_valid}, 32'd1);
            chk("seq_pc",    32'(out_pc), 32'(4 * i));
            chk("seq_inst",  out_inst, 32'(i));
        end

        // Stall with consumer blocked: queue fills with PCs 0..12.
        deq_ready = 1'b0;
        do_redirect(12'h000);
        repeat (10) @(negedge CLK);
        chk("full_pc",    32'(out_pc), 32'd0);
        chk("full_iaddr", 32'(iaddr), 32'd4);
        for (int i = 0; i < 6; i++) begin
            chk("drain_pc", 32'(out_pc), 32'(4 * i));
            deq_ready = 1'b1;
            @(negedge CLK);
        end

        // Redirect while full and pending.
        deq_ready = 1'b0;
        do_redirect(12'h200);
        repeat (4) @(negedge CLK);
        do_redirect(12'h103);
        deq_ready = 1'b1;
        chk("r1_valid0", {31'b0, out_valid}, 32'd0);
        @(negedge CLK);
        chk("r1_valid1", {31'b0, out_valid}, 32'd0);
        @(negedge CLK);
        chk("r1_valid2", {31'b0, out_valid}, 32'd1);
        chk("r1_pc",     32'(out_pc), 32'h100);
        chk("r1_inst",   out_inst, 32'h40);

        // Redirect concurrent with a dequeue of a valid head.
        do_redirect(12'h300);
        chk("r2_empty", {31'b0, out_valid}, 32'd0);
        repeat (2) @(negedge CLK);
        chk("r2_pc", 32'(out_pc), 32'h300);

        // Wrap at the top of the address space.
        do_redirect(12'hFFC);
        repeat (2) @(negedge CLK);
        chk("wrap_pc0",   32'(out_pc), 32'hFFC);
        chk("wrap_inst0", out_inst, 32'h3FF);
        @(negedge CLK);
        chk("wrap_pc1",   32'(out_pc), 32'h000);
        chk("wrap_inst1", out_inst, 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            deq_ready   = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = PC_W'($urandom);
            @(negedge CLK);
        end
        redirect  = 1'b0;
        deq_ready = 1'b1;
        repeat (5) @(negedge CLK);

        // Reset pulse mid-stream.
        #2 RESET_N = 1'b0;
        #1;
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_pc",    32'(out_pc), 32'd0);
        chk("mrst_inst",  out_inst, NOP);
        chk("mrst_iaddr", 32'(iaddr), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        chk("mrst_iaddr2", 32'(iaddr), 32'd0);
        repeat (2) @(negedge CLK);
        chk("mrst_first_pc", 32'(out_pc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            do_redirect(PC_W'($urandom));
            repeat (3) @(negedge CLK);
        end
`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_rcnt", 32'(redirect_count), 32'd3);
`endif
        repeat (20) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
